// File: rtl/mdu_seq_if.sv
// Bundle of the EX-side request and writeback-side result signals of mdu_seq.
// state_o exposes the sequencer state for observation only.
interface mdu_seq_if;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o;
   logic [1:0]  state_o;

   // Handshake: a request is accepted in any cycle where the sequencer is idle,
   // start_i=1 and flush_i=0; stall_o stays high until the done_o pulse, and
   // result_o/rd_addr_o are meaningful only while done_o=1.
   modport master (
      output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      input  stall_o, done_o, result_o, rd_addr_o, rd_we_o, state_o
   );

   modport slave (
      input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      output stall_o, done_o, result_o, rd_addr_o, rd_we_o, state_o
   );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply (radix-2 shift-add) sequencer beside EX.
// Define MDU_DIV_EN to add the restoring divider for funct3 4..7.
module mdu_seq #(
   parameter int XLEN      = 32,
   parameter bit EARLY_OUT = 1'b1
) (
   input logic      clk,
   input logic      rst,
   mdu_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t               state, state_nxt;
   logic [2:0]           op;
   logic                 neg;
   logic [XLEN-1:0]      opnd;
   logic [2*XLEN-1:0]    acc;
   logic [4:0]           count;
   logic [XLEN-1:0]      result_q;
   logic [4:0]           rd_q;

   logic                 accept, is_div, a_sgn, b_sgn, a_neg, b_neg, neg_nxt, short_cut;
   logic [XLEN-1:0]      a_mag, b_mag, short_res, calc_res;
   logic [XLEN:0]        mul_sum;
   logic [2*XLEN-1:0]    acc_step, prod;
`ifdef MDU_DIV_EN
   logic [XLEN:0]        trial;
   logic [XLEN-1:0]      rem_quo;
`endif

   // Request decode: operand signedness, magnitudes and single-cycle short-cuts.
   always_comb begin
      accept = bus.start_i & ~bus.flush_i;
      is_div = bus.funct3_i[2];
      if (is_div) begin
         a_sgn = ~bus.funct3_i[0];
         b_sgn = ~bus.funct3_i[0];
      end else begin
         a_sgn = (bus.funct3_i != 3'd3);
         b_sgn = ~bus.funct3_i[1];
      end
      a_neg     = a_sgn & bus.rs1_data_i[XLEN-1];
      b_neg     = b_sgn & bus.rs2_data_i[XLEN-1];
      a_mag     = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
      b_mag     = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;
      neg_nxt   = a_neg ^ b_neg;
      short_cut = !is_div && EARLY_OUT && (bus.rs1_data_i == '0 || bus.rs2_data_i == '0);
      short_res = '0;
`ifdef MDU_DIV_EN
      if (is_div && bus.funct3_i[1])
         neg_nxt = a_neg;
      if (is_div && bus.rs2_data_i == '0) begin
         short_cut = 1'b1;
         short_res = bus.funct3_i[1] ? bus.rs1_data_i : '1;
      end else if (is_div && !bus.funct3_i[0] && bus.rs2_data_i == '1 &&
                   bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) begin
         short_cut = 1'b1;
         short_res = bus.funct3_i[1] ? '0 : bus.rs1_data_i;
      end
`else
      if (is_div)
         short_cut = 1'b1;
`endif
   end

   // One iteration: acc holds {partial hi, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_step = {mul_sum, acc[XLEN-1:1]};
      prod     = neg ? -acc_step : acc_step;
      calc_res = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
      rem_quo  = '0;
      trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      if (op[2]) begin
         acc_step = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         rem_quo  = op[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
         calc_res = neg ? -rem_quo : rem_quo;
      end
`endif
   end

   always_comb begin
      state_nxt   = state;
      bus.stall_o = 1'b0;
      bus.done_o  = 1'b0;
      case (state)
         IDLE: begin
            bus.stall_o = accept & ~rst;
            if (accept)
               state_nxt = short_cut ? DONE : CALC;
         end
         CALC: begin
            bus.stall_o = ~rst;
            if (bus.flush_i)
               state_nxt = IDLE;
            else if (count == 5'd31)
               state_nxt = DONE;
         end
         DONE: begin
            bus.done_o = ~bus.flush_i;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op       <= '0;
         neg      <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         count    <= '0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (accept) begin
               op    <= bus.funct3_i;
               rd_q  <= bus.rd_addr_i;
               neg   <= neg_nxt;
               count <= '0;
               opnd  <= is_div ? b_mag : a_mag;
               acc   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
               if (short_cut)
                  result_q <= short_res;
            end
            CALC: begin
               acc   <= acc_step;
               count <= count + 5'd1;
               if (count == 5'd31 && !bus.flush_i)
                  result_q <= calc_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.result_o  = result_q;
   assign bus.rd_addr_o = rd_q;
   assign bus.rd_we_o   = bus.done_o;
   assign bus.state_o   = state;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomized bench for mdu_seq; honours MDU_DIV_EN like the design.
module tb_mdu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   mdu_seq_if bus ();

   mdu_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: architectural RV32M results computed with 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (f)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         default: begin
`ifdef MDU_DIV_EN
            if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
            if (!f[0]) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : a;
               p = f[1] ? sa % sb : sa / sb;
            end else begin
               p = f[1] ? ua % ub : ua / ub;
            end
            return p[31:0];
`else
            return 32'h0;
`endif
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      if (!f[2]) return (a == 0 || b == 0) ? 1 : 33;
`ifdef MDU_DIV_EN
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
`else
      return 1;
`endif
   endfunction

   // Call at posedge+1; returns at posedge+1 one cycle after the done pulse.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
      int          lat;
      int          exp_lat;
      logic [31:0] exp_res;
      exp_res = ref_result(f, a, b);
      exp_lat = ref_latency(f, a, b);
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'b0;
      bus.funct3_i   = f;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.rd_addr_i  = rd;
      #1;
      chk("stall_at_start", {31'b0, bus.stall_o}, 32'd1);
      chk("done_at_start", {31'b0, bus.done_o}, 32'd0);
      @(posedge clk); #1;
      bus.start_i    = 1'b0;
      bus.funct3_i   = 3'($urandom_range(0, 7));
      bus.rs1_data_i = $urandom;
      bus.rs2_data_i = $urandom;
      bus.rd_addr_i  = 5'($urandom_range(0, 31));
      lat = 1;
      while (!bus.done_o && lat < 40) begin
         chk("stall_busy", {31'b0, bus.stall_o}, 32'd1);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("done_pulse", {31'b0, bus.done_o}, 32'd1);
      chk("result", bus.result_o, exp_res);
      chk("rd_addr", {27'b0, bus.rd_addr_o}, {27'b0, rd});
      chk("rd_we", {31'b0, bus.rd_we_o}, 32'd1);
      chk("stall_in_done", {31'b0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      chk("done_fall", {31'b0, bus.done_o}, 32'd0);
      chk("result_hold", bus.result_o, exp_res);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.start_i    = 1'b0;
      bus.flush_i    = 1'b0;
      bus.funct3_i   = 3'd0;
      bus.rs1_data_i = 32'h0;
      bus.rs2_data_i = 32'h0;
      bus.rd_addr_i  = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", {31'b0, bus.done_o}, 32'd0);
      chk("reset_result", bus.result_o, 32'h0);
      chk("reset_rd_addr", {27'b0, bus.rd_addr_o}, 32'd0);
      chk("reset_rd_we", {31'b0, bus.rd_we_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_stall", {31'b0, bus.stall_o}, 32'd0);

      // Directed cases
      run_op(3'd0, 32'd7, 32'd6, 5'd5);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
      run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      run_op(3'd0, 32'h0, 32'h1234_5678, 5'd6);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
      run_op(3'd4, 32'd100, 32'd0, 5'd9);
      run_op(3'd7, 32'd100, 32'd0, 5'd10);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
      run_op(3'd5, 32'd10, 32'd2, 5'd12);

      // Flush in CALC: start at T, flush at T+10
      bus.start_i = 1'b1; bus.funct3_i = 3'd0;
      bus.rs1_data_i = 32'd11; bus.rs2_data_i = 32'd13; bus.rd_addr_i = 5'd14;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      #1;
      chk("flush_calc_done", {31'b0, bus.done_o}, 32'd0);
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      #1;
      chk("flush_stall_drop", {31'b0, bus.stall_o}, 32'd0);
      chk("flush_no_done", {31'b0, bus.done_o}, 32'd0);
      @(posedge clk); #1;
      run_op(3'd0, 32'd3, 32'd3, 5'd15);

      // Flush together with start in IDLE drops the request
      bus.start_i = 1'b1; bus.flush_i = 1'b1;
      bus.funct3_i = 3'd0; bus.rs1_data_i = 32'd5; bus.rs2_data_i = 32'd5;
      #1;
      chk("flush_idle_stall", {31'b0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      #1;
      chk("flush_idle_stall_after", {31'b0, bus.stall_o}, 32'd0);
      repeat (35) begin
         @(posedge clk); #1;
         chk("flush_idle_no_done", {31'b0, bus.done_o}, 32'd0);
      end

      // Reset in the middle of a multiply; start_i held high during reset
      bus.start_i = 1'b1; bus.funct3_i = 3'd0;
      bus.rs1_data_i = 32'd21; bus.rs2_data_i = 32'd2; bus.rd_addr_i = 5'd17;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; bus.start_i = 1'b1;
      @(posedge clk); #1;
      chk("midrst_done", {31'b0, bus.done_o}, 32'd0);
      chk("midrst_result", bus.result_o, 32'h0);
      chk("midrst_rd_addr", {27'b0, bus.rd_addr_o}, 32'd0);
      chk("midrst_rd_we", {31'b0, bus.rd_we_o}, 32'd0);
      chk("midrst_stall", {31'b0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; bus.start_i = 1'b0;
      #1;
      chk("postrst_stall", {31'b0, bus.stall_o}, 32'd0);
      repeat (35) begin
         @(posedge clk); #1;
         chk("postrst_no_done", {31'b0, bus.done_o}, 32'd0);
      end

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                5'($urandom_range(0, 31)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for RV32M multiply (and, optionally, divide/remainder) operations flagged by EX via use_mult.
- Latches operands, runs an iterative radix-2 shift-add multiplier (or restoring divider), stalls the pipeline while busy, then returns the result with rd write info for writeback.
- Sits beside EX; its result is muxed into the EX/MEM rd_data path in the cycle done_o is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- EARLY_OUT, 1, when 1 a multiply with a zero operand skips CALC and goes straight to DONE.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  use_mult from EX; request a new operation
- funct3_i  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_data_i  input  32  operand A (multiplicand/dividend)
- rs2_data_i  input  32  operand B (multiplier/divisor)
- rd_addr_i  input  5  destination register
- flush_i  input  1  abort the current operation (branch/jump redirect)
- stall_o  output  1  freeze IF/ID/EX
- done_o  output  1  result valid, one-cycle pulse
- result_o  output  32  result, valid while done_o=1
- rd_addr_o  output  5  latched rd, valid with done_o
- rd_we_o  output  1  equals done_o

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, count 0, accumulators 0; done_o=0, result_o=0, rd_addr_o=0, rd_we_o=0. rst overrides everything, including mid-operation.
- States:
  - IDLE: if start_i=1 and flush_i=0, latch funct3, operands and rd_addr, then go to CALC (or DONE for a short-cut).
  - CALC: one bit per cycle; count runs 0..31. After the cycle with count=31, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE. A start_i in DONE is ignored; EX re-presents it after the stall drops.
- stall_o is combinational: (IDLE and start_i and !flush_i) or CALC. It is 0 in DONE, so the pipeline advances and captures the result.
- Latency:
  - Start sampled in cycle T; CALC occupies T+1..T+32; done_o is high in T+33.
  - Short-cuts (early-out, divide by zero, overflow): done_o high in T+1.
- Multiply:
  - Operands are converted to magnitudes plus a result-sign flag. MUL/MULH: signed x signed. MULHSU: signed x unsigned. MULHU: unsigned x unsigned.
  - A 64-bit unsigned product accumulates over 32 cycles and is two's-complement negated in the DONE transition if the sign flag is set.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide (with MDU_DIV_EN):
  - 32-cycle restoring division on magnitudes.
  - Quotient is negative iff the operand signs differ (signed ops only); remainder takes the dividend's sign.
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Operand inputs are ignored after latching; start_i in CALC is ignored.
- Flush:
  - flush_i=1 in CALC or DONE: next state IDLE, no done_o pulse.
  - flush_i=1 in IDLE with start_i=1: the request is dropped.
- result_o and rd_addr_o hold their last values after done_o falls. Consumers must qualify with done_o.

Optional Feature:
- Macro: MDU_DIV_EN.
- Defined: funct3 4..7 execute the divider described above, which shares the count, state machine and accumulator registers.
- Undefined: a start with funct3[2]=1 goes IDLE->DONE in one cycle with result_o=0 and done_o=1, so the pipeline never hangs; no divider logic is synthesized.

Test Plan:
- MUL 7 x 6 at T -> stall_o high T..T+32, done_o only at T+33, result_o=42, rd_addr_o echoes rd_addr_i=5.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHSU same operands -> 0xFFFFFFFF; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001.
- EARLY_OUT=1, MUL 0 x 0x12345678 -> done_o at T+1, result_o=0, stall_o high only in T.
- MDU_DIV_EN defined:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, both at T+33.
  - DIV 100 / 0 -> 0xFFFFFFFF at T+1; REMU 100 / 0 -> 100.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- MUL started at T, flush_i at T+10 -> IDLE at T+11, stall_o=0 from T+11, no done_o; a new MUL 3 x 3 at T+12 -> 9 at T+45.
- rst asserted at T+5 of a MUL -> all outputs 0 next cycle; start_i ignored while rst=1. MDU_DIV_EN undefined: DIVU 10 / 2 -> done_o at T+1, result_o=0.
